// File: rtl/if_fetch_unit_pkg.sv
// if_fetch_unit_pkg: shared instruction-fetch stage constants and state encoding
package if_fetch_unit_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int          INSTR_W          = 32;
    localparam int          PC_INC           = 4;

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_FETCH = 2'd1,
        ST_STALL = 2'd2,
        ST_DROP  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/if_fetch_unit_skid_buf.sv
// fetch_skid_buf: one-entry instruction/PC holding register with load, unload and clear
module fetch_skid_buf
    import if_fetch_unit_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               unload,
    input  logic               clear,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [ADDR_W-1:0]  in_pc,
    output logic               full,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  pc
);

    // clear beats load beats unload; the data is kept on unload and only the flag drops
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full  <= 1'b0;
            instr <= '0;
            pc    <= '0;
        end else if (clear) begin
            full <= 1'b0;
        end else if (load) begin
            full  <= 1'b1;
            instr <= in_instr;
            pc    <= in_pc;
        end else if (unload) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction fetch stage owning the PC, imem handshake, skid buffer and redirects
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instruction_out,
    output logic [ADDR_W-1:0]  PCNow_out,
    output logic [ADDR_W-1:0]  PCNext4_out,
    output logic               valid_out
);

    fetch_state_t       state;
    logic [ADDR_W-1:0]  req_pc;
    logic [ADDR_W-1:0]  redir_pc;
    logic [ADDR_W-1:0]  target;
    logic [ADDR_W-1:0]  req_pc_inc;
    logic               skid_load;
    logic               skid_unload;
    logic               skid_full;
    logic [INSTR_W-1:0] skid_instr;
    logic [ADDR_W-1:0]  skid_pc;

    assign target      = {redirect_pc[ADDR_W-1:2], 2'b00};
    assign req_pc_inc  = req_pc + ADDR_W'(PC_INC);
    assign imem_req    = (state == ST_FETCH) || (state == ST_DROP);
    assign imem_addr   = req_pc;
    assign skid_load   = (state == ST_FETCH) && imem_ack && !redirect && valid_out && stall;
    assign skid_unload = (state == ST_STALL) && !redirect && !stall && skid_full;

    fetch_skid_buf #(.ADDR_W(ADDR_W)) u_skid (
        .clk      (clk),
        .rst      (rst),
        .load     (skid_load),
        .unload   (skid_unload),
        .clear    (redirect),
        .in_instr (imem_rdata),
        .in_pc    (req_pc),
        .full     (skid_full),
        .instr    (skid_instr),
        .pc       (skid_pc)
    );

    // fetch FSM: PC sequencing, output slot updates and redirect/drop handling
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= ST_START;
            req_pc          <= RESET_PC;
            redir_pc        <= '0;
            valid_out       <= 1'b0;
            instruction_out <= '0;
            PCNow_out       <= '0;
            PCNext4_out     <= '0;
        end else begin
            case (state)
                ST_START: begin
                    state     <= ST_FETCH;
                    valid_out <= 1'b0;
                    if (redirect) req_pc <= target;
                end
                ST_FETCH: begin
                    if (redirect) begin
                        valid_out <= 1'b0;
                        if (imem_ack) begin
                            req_pc <= target;
                        end else begin
                            redir_pc <= target;
                            state    <= ST_DROP;
                        end
                    end else if (imem_ack) begin
                        req_pc <= req_pc_inc;
                        if (!valid_out || !stall) begin
                            instruction_out <= imem_rdata;
                            PCNow_out       <= req_pc;
                            PCNext4_out     <= req_pc_inc;
                            valid_out       <= 1'b1;
                        end else begin
                            state <= ST_STALL;
                        end
                    end else if (valid_out && !stall) begin
                        valid_out <= 1'b0;
                    end
                end
                ST_STALL: begin
                    if (redirect) begin
                        valid_out <= 1'b0;
                        req_pc    <= target;
                        state     <= ST_FETCH;
                    end else if (skid_unload) begin
                        instruction_out <= skid_instr;
                        PCNow_out       <= skid_pc;
                        PCNext4_out     <= skid_pc + ADDR_W'(PC_INC);
                        valid_out       <= 1'b1;
                        state           <= ST_FETCH;
                    end
                end
                ST_DROP: begin
                    valid_out <= 1'b0;
                    if (redirect) begin
                        redir_pc <= target;
                        if (imem_ack) begin
                            req_pc <= target;
                            state  <= ST_FETCH;
                        end
                    end else if (imem_ack) begin
                        req_pc <= redir_pc;
                        state  <= ST_FETCH;
                    end
                end
                default: state <= ST_START;
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed self-checking bench for the instruction fetch stage
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instruction_out;
    logic [31:0] PCNow_out;
    logic [31:0] PCNext4_out;
    logic        valid_out;
    logic        ack_en = 1'b0;
    int          vectors = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    // memory model: answers in the request cycle when enabled; data is the inverted address
    assign imem_ack   = imem_req & ack_en;
    assign imem_rdata = ~imem_addr;

    if_fetch_unit dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .instruction_out (instruction_out),
        .PCNow_out       (PCNow_out),
        .PCNext4_out     (PCNext4_out),
        .valid_out       (valid_out)
    );

    always @(posedge clk) begin
        if (rst && imem_ack && !imem_req) begin
            errors++;
            $display("FAIL ack_without_req: imem_ack=1 with imem_req=0 at %0t", $time);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        ack_en = 1'b1;
        tick();
        tick();
        vectors++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid_out); end
        vectors++; if (instruction_out !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h want 0", instruction_out); end
        vectors++; if (PCNow_out !== 32'h0) begin errors++; $display("FAIL reset_pcnow: got %h want 0", PCNow_out); end
        vectors++; if (PCNext4_out !== 32'h0) begin errors++; $display("FAIL reset_pcnext4: got %h want 0", PCNext4_out); end
        vectors++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", imem_req); end
        rst = 1'b1;
        vectors++; if (imem_req !== 1'b0) begin errors++; $display("FAIL start_req: got %b want 0", imem_req); end
        tick();
        vectors++; if (imem_req !== 1'b1) begin errors++; $display("FAIL first_req: got %b want 1", imem_req); end
        vectors++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL first_addr: got %h want 0", imem_addr); end
    endtask

    task automatic test_stream();
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++; if (valid_out !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d]: got %b want 1", i, valid_out); end
            vectors++; if (PCNow_out !== 32'(4 * i)) begin errors++; $display("FAIL stream_pcnow[%0d]: got %h want %h", i, PCNow_out, 32'(4 * i)); end
            vectors++; if (PCNext4_out !== 32'(4 * i + 4)) begin errors++; $display("FAIL stream_pcnext4[%0d]: got %h want %h", i, PCNext4_out, 32'(4 * i + 4)); end
            vectors++; if (instruction_out !== ~32'(4 * i)) begin errors++; $display("FAIL stream_instr[%0d]: got %h want %h", i, instruction_out, ~32'(4 * i)); end
            vectors++; if (imem_addr !== 32'(4 * i + 4)) begin errors++; $display("FAIL stream_addr[%0d]: got %h want %h", i, imem_addr, 32'(4 * i + 4)); end
        end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req[%0d]: got %b want 0", i, imem_req); end
            vectors++; if (PCNow_out !== 32'h4) begin errors++; $display("FAIL stall_pcnow[%0d]: got %h want 4", i, PCNow_out); end
            vectors++; if (valid_out !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d]: got %b want 1", i, valid_out); end
        end
        stall = 1'b0;
        tick();
        vectors++; if (PCNow_out !== 32'h8) begin errors++; $display("FAIL unstall_pcnow: got %h want 8", PCNow_out); end
        vectors++; if (PCNext4_out !== 32'hC) begin errors++; $display("FAIL unstall_pcnext4: got %h want c", PCNext4_out); end
        vectors++; if (instruction_out !== ~32'h8) begin errors++; $display("FAIL unstall_instr: got %h want %h", instruction_out, ~32'h8); end
        vectors++; if (imem_addr !== 32'hC || imem_req !== 1'b1) begin errors++; $display("FAIL resume_addr: got %h/%b want c/1", imem_addr, imem_req); end
        tick();
        vectors++; if (PCNow_out !== 32'hC) begin errors++; $display("FAIL resume_pcnow: got %h want c", PCNow_out); end
        vectors++; if (imem_addr !== 32'h10) begin errors++; $display("FAIL resume_next_addr: got %h want 10", imem_addr); end
    endtask

    task automatic test_redirect_drop();
        ack_en = 1'b0;
        redirect = 1'b1;
        redirect_pc = 32'h0000_0103;
        tick();
        redirect = 1'b0;
        vectors++; if (valid_out !== 1'b0) begin errors++; $display("FAIL drop_valid: got %b want 0", valid_out); end
        vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin errors++; $display("FAIL drop_hold: got %b/%h want 1/10", imem_req, imem_addr); end
        tick();
        vectors++; if (imem_addr !== 32'h10) begin errors++; $display("FAIL drop_hold2: got %h want 10", imem_addr); end
        ack_en = 1'b1;
        tick();
        vectors++; if (valid_out !== 1'b0) begin errors++; $display("FAIL drop_discard: got valid %b want 0", valid_out); end
        vectors++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL drop_target: got %h want 100", imem_addr); end
        tick();
        vectors++; if (valid_out !== 1'b1 || PCNow_out !== 32'h100) begin errors++; $display("FAIL drop_refetch: got %b/%h want 1/100", valid_out, PCNow_out); end
        vectors++; if (instruction_out !== ~32'h100) begin errors++; $display("FAIL drop_instr: got %h want %h", instruction_out, ~32'h100); end
    endtask

    task automatic test_redirect_ack_stall();
        stall = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'h0000_0200;
        tick();
        redirect = 1'b0;
        stall = 1'b0;
        vectors++; if (valid_out !== 1'b0) begin errors++; $display("FAIL ras_valid: got %b want 0", valid_out); end
        vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin errors++; $display("FAIL ras_addr: got %b/%h want 1/200", imem_req, imem_addr); end
        tick();
        vectors++; if (valid_out !== 1'b1 || PCNow_out !== 32'h200) begin errors++; $display("FAIL ras_out: got %b/%h want 1/200", valid_out, PCNow_out); end
        vectors++; if (imem_addr !== 32'h204) begin errors++; $display("FAIL ras_next: got %h want 204", imem_addr); end
    endtask

    task automatic test_wrap();
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        vectors++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr: got %h want fffffffc", imem_addr); end
        tick();
        vectors++; if (PCNow_out !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pcnow: got %h want fffffffc", PCNow_out); end
        vectors++; if (PCNext4_out !== 32'h0) begin errors++; $display("FAIL wrap_pcnext4: got %h want 0", PCNext4_out); end
        vectors++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_next_addr: got %h want 0", imem_addr); end
        tick();
        vectors++; if (PCNow_out !== 32'h0 || PCNext4_out !== 32'h4) begin errors++; $display("FAIL wrap_after: got %h/%h want 0/4", PCNow_out, PCNext4_out); end
    endtask

    task automatic test_async_reset_drop();
        ack_en = 1'b0;
        redirect = 1'b1;
        redirect_pc = 32'h0000_0040;
        tick();
        redirect = 1'b0;
        vectors++; if (imem_req !== 1'b1 || PCNow_out !== 32'h0) begin errors++; $display("FAIL pre_reset_drop: got %b/%h want 1/0", imem_req, PCNow_out); end
        vectors++; if (PCNext4_out !== 32'h4) begin errors++; $display("FAIL pre_reset_pcnext4: got %h want 4", PCNext4_out); end
        #2;
        rst = 1'b0;
        #1;
        vectors++; if (PCNext4_out !== 32'h0 || instruction_out !== 32'h0) begin errors++; $display("FAIL async_reset_out: got %h/%h want 0/0", PCNext4_out, instruction_out); end
        vectors++; if (imem_req !== 1'b0 || valid_out !== 1'b0) begin errors++; $display("FAIL async_reset_req: got %b/%b want 0/0", imem_req, valid_out); end
        ack_en = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL post_reset_addr: got %b/%h want 1/0", imem_req, imem_addr); end
        tick();
        vectors++; if (valid_out !== 1'b1 || PCNow_out !== 32'h0) begin errors++; $display("FAIL post_reset_out: got %b/%h want 1/0", valid_out, PCNow_out); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_drop();
        test_redirect_ack_stall();
        test_wrap();
        test_async_reset_drop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
